// File: rtl/rst_cipher_stream_pkg.sv
// Shared constants, state encoding and character helpers for the RST cipher stream.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package rst_cipher_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UZ = 8'h5A;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LZ = 8'h7A;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_BAD_CHAR = 2'b01;
  localparam logic [1:0] ST_NO_KEY   = 2'b10;

  localparam int KEY_LEN = 12;

  typedef enum logic [1:0] {S_NOKEY, S_CHECK, S_READY} state_t;

  function automatic logic is_alnum(input logic [7:0] c);
    return (c >= ASCII_0 && c <= ASCII_9) || (c >= ASCII_UA && c <= ASCII_UZ) ||
           (c >= ASCII_LA && c <= ASCII_LZ);
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return (c >= ASCII_UA && c <= ASCII_UZ) ? c + 8'd32 : c;
  endfunction

  // Letters map to cells 0..25, digits to 26..35; only meaningful for alnum input.
  function automatic logic [5:0] char_to_cell(input logic [7:0] c);
    logic [7:0] lc;
    lc = to_lower(c);
    return (lc >= ASCII_LA) ? 6'(lc - ASCII_LA) : 6'(lc - ASCII_0 + 8'd26);
  endfunction

  function automatic logic [7:0] cell_to_char(input logic [5:0] p);
    return (p < 6'd26) ? ASCII_LA + {2'b00, p} : ASCII_0 + {2'b00, p} - 8'd26;
  endfunction

  // Key byte i, with k0 in the most significant byte.
  function automatic logic [7:0] key_byte(input logic [95:0] k, input logic [3:0] i);
    logic [7:0] b;
    b = '0;
    for (int j = 0; j < KEY_LEN; j++) begin
      if (i == 4'(j)) b = k[95-8*j -: 8];
    end
    return b;
  endfunction

  // Row header slot b (0..5) holds key byte 0,10,2,8,4,6; the column slot is the next byte.
  function automatic logic [3:0] row_key_idx(input logic [2:0] b);
    return b[0] ? 4'd11 - {1'b0, b} : {1'b0, b};
  endfunction

endpackage

// File: rtl/rst_cipher_stream_if.sv
// Key, input and output valid/ready channels of the RST cipher stream.
// Latency: n/a (wiring only).
// Backpressure: each channel transfers when its valid and ready are both high.
interface rst_cipher_stream_if;
  logic        key_valid;
  logic        key_ready;
  logic [95:0] key;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_status;

  modport master (
    output key_valid, key, in_valid, in_mode, in_data, out_ready,
    input  key_ready, in_ready, out_valid, out_data, out_status
  );

  modport slave (
    input  key_valid, key, in_valid, in_mode, in_data, out_ready,
    output key_ready, in_ready, out_valid, out_data, out_status
  );
endinterface

// File: rtl/rst_cipher_stream_key_checker.sv
// Sequential key validator: one key byte per cycle, alnum and no repeat of an earlier byte.
// Latency: done is high in the 12th cycle after start, with fail valid alongside it.
// Backpressure: none; a new start restarts the scan from byte 0.
module rst_key_checker
  import rst_cipher_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [95:0] key,
  output logic        done,
  output logic        fail
);

  logic       running;
  logic [3:0] idx;
  logic       flag;
  logic [7:0] cur;
  logic       dup;
  logic       cur_bad;

  // Evaluate the byte under the cursor against the alnum set and all earlier bytes.
  always_comb begin
    cur = key_byte(key, idx);
    dup = 1'b0;
    for (int j = 0; j < KEY_LEN; j++) begin
      if (4'(j) < idx && key_byte(key, 4'(j)) == cur) dup = 1'b1;
    end
    cur_bad = !is_alnum(cur) || dup;
  end

  assign done = running && (idx == 4'(KEY_LEN - 1));
  assign fail = flag || cur_bad;

  // Walk the cursor across the key and accumulate any flagged byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      idx     <= '0;
      flag    <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      idx     <= '0;
      flag    <= 1'b0;
    end else if (running) begin
      flag <= flag || cur_bad;
      if (done) running <= 1'b0;
      else      idx     <= idx + 4'd1;
    end
  end

endmodule

// File: rtl/rst_cipher_stream.sv
// Streaming RST cipher: key install with 12-cycle check, then encrypt/decrypt one char per beat.
// Latency: a beat accepted in cycle N presents its registered result in cycle N+1.
// Backpressure: input stalls while the result is held by out_ready low; key offers win over input.
module rst_cipher_stream
  import rst_cipher_pkg::*;
#(
  parameter int ROT_STEP    = 1,
  parameter bit ALLOW_REKEY = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rst_cipher_stream_if.slave   bus,
  output logic                 key_installed,
  output logic                 err_invalid_key
);

  state_t      state;
  logic [95:0] key_reg;
  logic [2:0]  offset;
  logic        chk_done;
  logic        chk_fail;
  logic        key_acc;
  logic        in_acc;
  logic [5:0]  p_cell;
  logic [7:0]  enc_row;
  logic [7:0]  enc_col;
  logic        enc_ok;
  logic [2:0]  rq;
  logic [2:0]  cq;
  logic        rm;
  logic        cm;
  logic [7:0]  dec_char;

  function automatic logic [2:0] sub6(input logic [2:0] q, input logic [2:0] off);
    return 3'((q >= off) ? {1'b0, q} - {1'b0, off} : {1'b0, q} + 4'd6 - {1'b0, off});
  endfunction

  function automatic logic [2:0] add6(input logic [2:0] b, input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, b} + {1'b0, off};
    return (s >= 4'd6) ? 3'(s - 4'd6) : 3'(s);
  endfunction

  assign bus.key_ready = (state == S_NOKEY) || (ALLOW_REKEY && state == S_READY);
  assign key_acc       = bus.key_valid && bus.key_ready;
  // Held low while reset is asserted so nothing is offered before the block is live.
  assign bus.in_ready  = rst_n && (state == S_NOKEY || state == S_READY) &&
                         (!bus.out_valid || bus.out_ready) && !key_acc;
  assign in_acc        = bus.in_valid && bus.in_ready;

  rst_key_checker u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .start (key_acc),
    .key   (key_reg),
    .done  (chk_done),
    .fail  (chk_fail)
  );

  // Encrypt looks headers up through the rotation; decrypt searches the rotated headers.
  always_comb begin
    enc_ok  = is_alnum(bus.in_data[7:0]);
    p_cell  = char_to_cell(bus.in_data[7:0]);
    enc_row = key_byte(key_reg, row_key_idx(sub6(3'(p_cell / 6'd6), offset)));
    enc_col = key_byte(key_reg, row_key_idx(sub6(3'(p_cell % 6'd6), offset)) + 4'd1);
    rq = '0;
    cq = '0;
    rm = 1'b0;
    cm = 1'b0;
    for (int b = 0; b < 6; b++) begin
      if (key_byte(key_reg, row_key_idx(3'(b))) == bus.in_data[15:8]) begin
        rm = 1'b1;
        rq = add6(3'(b), offset);
      end
      if (key_byte(key_reg, row_key_idx(3'(b)) + 4'd1) == bus.in_data[7:0]) begin
        cm = 1'b1;
        cq = add6(3'(b), offset);
      end
    end
    dec_char = cell_to_char(6'(rq) * 6'd6 + 6'(cq));
  end

  // Key-install FSM plus the registered result beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_NOKEY;
      key_reg         <= '0;
      offset          <= '0;
      key_installed   <= 1'b0;
      err_invalid_key <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_status  <= ST_OK;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

      if (in_acc) begin
        bus.out_valid <= 1'b1;
        if (state == S_NOKEY) begin
          bus.out_data   <= '0;
          bus.out_status <= ST_NO_KEY;
        end else if (!bus.in_mode) begin
          if (enc_ok) begin
            bus.out_data   <= {enc_row, enc_col};
            bus.out_status <= ST_OK;
            offset         <= add6(offset, 3'(ROT_STEP));
          end else begin
            bus.out_data   <= '0;
            bus.out_status <= ST_BAD_CHAR;
          end
        end else begin
          if (rm && cm) begin
            bus.out_data   <= {8'h00, dec_char};
            bus.out_status <= ST_OK;
            offset         <= add6(offset, 3'(ROT_STEP));
          end else begin
            bus.out_data   <= '0;
            bus.out_status <= ST_BAD_CHAR;
          end
        end
      end

      if (key_acc) begin
        key_reg         <= bus.key;
        err_invalid_key <= 1'b0;
        key_installed   <= 1'b0;
        state           <= S_CHECK;
      end else if (state == S_CHECK && chk_done) begin
        if (chk_fail) begin
          err_invalid_key <= 1'b1;
          state           <= S_NOKEY;
        end else begin
          key_installed <= 1'b1;
          offset        <= '0;
          state         <= S_READY;
        end
      end
    end
  end

endmodule

// File: tb/tb_rst_cipher_stream.sv
// Scoreboard bench: two instances (ROT_STEP 1 and 2) driven in lockstep from one stimulus.
// Latency: expected beats are queued at input acceptance and popped at output handshake.
// Backpressure: the sink runs always-ready, stalled, or random depending on the phase.
module tb_rst_cipher_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rst_cipher_stream_if b1();
  rst_cipher_stream_if b2();
  logic ki1, ei1, ki2, ei2;

  rst_cipher_stream #(.ROT_STEP(1), .ALLOW_REKEY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .key_installed(ki1), .err_invalid_key(ei1));
  rst_cipher_stream #(.ROT_STEP(2), .ALLOW_REKEY(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave), .key_installed(ki2), .err_invalid_key(ei2));

  assign b2.key_valid = b1.key_valid;
  assign b2.key       = b1.key;
  assign b2.in_valid  = b1.in_valid;
  assign b2.in_mode   = b1.in_mode;
  assign b2.in_data   = b1.in_data;
  assign b2.out_ready = b1.out_ready;

  typedef struct {
    logic [15:0] d1;
    logic [1:0]  s1;
    logic [15:0] d2;
    logic [1:0]  s2;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int sink_mode = 0;
  int stalls = 0;
  logic [95:0] mkey = '0;
  bit m_inst = 1'b0;
  int off1 = 0;
  int off2 = 0;
  int rlist[6] = '{0, 10, 2, 8, 4, 6};
  int clist[6] = '{1, 11, 3, 9, 5, 7};
  string CHARSET = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
  string BADSET = "!#-_ ~@[";
  logic [95:0] K_GOOD = "abcdefghijkl";
  logic [95:0] K_DUP  = "abcdefghijka";
  logic [95:0] K_BANG = "abcdefghijk!";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] kb(input logic [95:0] k, input int i);
    return k[95-8*i -: 8];
  endfunction

  function automatic bit m_alnum(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  function automatic bit m_key_ok(input logic [95:0] k);
    for (int i = 0; i < 12; i++) begin
      if (!m_alnum(kb(k, i))) return 1'b0;
      for (int j = 0; j < i; j++) if (kb(k, j) == kb(k, i)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Header shown at position pos (1..6) after rotating by off.
  function automatic logic [7:0] eff_r(input int pos, input int off);
    return kb(mkey, rlist[(((pos - 1 - off) % 6) + 6) % 6]);
  endfunction
  function automatic logic [7:0] eff_c(input int pos, input int off);
    return kb(mkey, clist[(((pos - 1 - off) % 6) + 6) % 6]);
  endfunction

  task automatic model_beat(input bit mode, input logic [15:0] d, input int rot, inout int off,
                            output logic [15:0] ed, output logic [1:0] es);
    int p, ri, ci;
    logic [7:0] c;
    ed = 16'h0000;
    es = 2'b01;
    if (!m_inst) begin
      es = 2'b10;
    end else if (!mode) begin
      c = d[7:0];
      if (m_alnum(c)) begin
        if (c >= "A" && c <= "Z") c = c + 8'd32;
        p = (c >= "a") ? int'(c) - 97 : 26 + int'(c) - 48;
        ed = {eff_r(p / 6 + 1, off), eff_c(p % 6 + 1, off)};
        es = 2'b00;
        off = (off + rot) % 6;
      end
    end else begin
      ri = 0;
      ci = 0;
      for (int i = 1; i <= 6; i++) begin
        if (eff_r(i, off) == d[15:8]) ri = i;
        if (eff_c(i, off) == d[7:0]) ci = i;
      end
      if (ri != 0 && ci != 0) begin
        p = (ri - 1) * 6 + (ci - 1);
        ed = {8'h00, (p < 26) ? 8'(97 + p) : 8'(48 + p - 26)};
        es = 2'b00;
        off = (off + rot) % 6;
      end
    end
  endtask

  function automatic logic [95:0] rand_key();
    logic [95:0] k;
    logic [7:0] c;
    bit dup;
    int pos, src;
    k = '0;
    for (int i = 0; i < 12; i++) begin
      do begin
        c = 8'(CHARSET[$urandom_range(0, 61)]);
        dup = 1'b0;
        for (int j = 0; j < i; j++) if (k[95-8*j -: 8] == c) dup = 1'b1;
      end while (dup);
      k[95-8*i -: 8] = c;
    end
    pos = $urandom_range(1, 11);
    case ($urandom_range(0, 3))
      0: begin src = $urandom_range(0, pos - 1); k[95-8*pos -: 8] = k[95-8*src -: 8]; end
      1: k[95-8*pos -: 8] = 8'(BADSET[$urandom_range(0, 7)]);
      default: ;
    endcase
    return k;
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input bit mode, input logic [15:0] d);
    int n;
    exp_t e;
    b1.in_valid = 1'b1;
    b1.in_mode = mode;
    b1.in_data = d;
    n = 0;
    @(negedge clk);
    while (!b1.in_ready && n < 200) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (!b1.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end else begin
      check("rot2_in_ready", b2.in_ready, 1);
      model_beat(mode, d, 1, off1, e.d1, e.s1);
      model_beat(mode, d, 2, off2, e.d2, e.s2);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    b1.in_valid = 1'b0;
  endtask

  task automatic install(input logic [95:0] k, input bit with_beat);
    int n;
    bit ok;
    b1.key = k;
    b1.key_valid = 1'b1;
    if (with_beat) begin
      b1.in_valid = 1'b1;
      b1.in_mode = 1'b0;
      b1.in_data = 16'h0061;
    end
    n = 0;
    @(negedge clk);
    while (!b1.key_ready && n < 200) begin @(negedge clk); n++; end
    check("key_ready_offer", b1.key_ready, 1);
    check("key_ready_rot2", b2.key_ready, 1);
    check("key_prio_in_ready", b1.in_ready, 0);
    @(posedge clk);
    #1;
    b1.key_valid = 1'b0;
    b1.in_valid = 1'b0;
    m_inst = 1'b0;
    mkey = k;
    ok = m_key_ok(k);
    n = 0;
    while (!(ki1 || ei1) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 6) check("in_ready_during_check", b1.in_ready, 0);
    end
    check("check_cycles", n, 12);
    check("key_installed", ki1, ok);
    check("err_invalid_key", ei1, !ok);
    check("key_installed_rot2", ki2, ok);
    check("err_invalid_key_rot2", ei2, !ok);
    m_inst = ok;
    off1 = 0;
    off2 = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_key_ready"}, b1.key_ready, 1);
    check({tag, "_in_ready"}, b1.in_ready, 0);
    check({tag, "_out_valid"}, b1.out_valid, 0);
    check({tag, "_out_data"}, b1.out_data, 0);
    check({tag, "_out_status"}, b1.out_status, 0);
    check({tag, "_key_installed"}, ki1, 0);
    check({tag, "_err_invalid_key"}, ei1, 0);
  endtask

  // Sink: always ready, stalled, or random per cycle.
  initial begin
    b1.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        0: b1.out_ready = 1'b1;
        1: b1.out_ready = 1'b0;
        default: b1.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: held beats must stay stable; each handshake pops one expected entry.
  initial begin
    logic [15:0] pd;
    logic [1:0] ps;
    bit hold;
    exp_t e;
    hold = 1'b0;
    pd = '0;
    ps = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", b1.out_valid, 1);
          check("hold_data", b1.out_data, pd);
          check("hold_status", b1.out_status, ps);
        end
        if (b1.out_valid && b1.out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: data %h status %b, required no beat", b1.out_data, b1.out_status);
          end else begin
            e = q.pop_front();
            check("beat_data_rot1", b1.out_data, e.d1);
            check("beat_status_rot1", b1.out_status, e.s1);
            check("beat_valid_rot2", b2.out_valid, 1);
            check("beat_data_rot2", b2.out_data, e.d2);
            check("beat_status_rot2", b2.out_status, e.s2);
          end
        end
        hold = b1.out_valid && !b1.out_ready;
        pd = b1.out_data;
        ps = b1.out_status;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion before 500us");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit mode;
    logic [15:0] d;
    b1.key_valid = 1'b0;
    b1.key = '0;
    b1.in_valid = 1'b0;
    b1.in_mode = 1'b0;
    b1.in_data = '0;

    #12;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic encrypt with rotation, then decrypt after a re-key resets the offset.
    install(K_GOOD, 1'b0);
    send(1'b0, 16'h0061);
    send(1'b0, 16'h0041);
    install(K_GOOD, 1'b1);
    send(1'b1, 16'h6162);
    send(1'b1, 16'h7A7A);
    send(1'b0, 16'h0061);
    install(K_GOOD, 1'b0);
    send(1'b0, 16'h0021);
    send(1'b0, 16'h0039);

    // Bad keys leave the block without a key.
    install(K_DUP, 1'b0);
    install(K_BANG, 1'b0);
    send(1'b0, 16'h0061);

    // Backpressure: stalled sink blocks input and freezes the held beat.
    install(K_GOOD, 1'b0);
    sink_mode = 1;
    @(posedge clk);
    #1;
    send(1'b0, 16'h0062);
    b1.in_valid = 1'b1;
    b1.in_mode = 1'b0;
    b1.in_data = 16'h0063;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", b1.in_ready, 0);
    end
    b1.in_valid = 1'b0;
    sink_mode = 0;
    @(posedge clk);
    #1;
    stalls = 0;
    for (int i = 0; i < 8; i++) send(1'b0, {8'h00, 8'(CHARSET[$urandom_range(0, 61)])});
    check("throughput_stalls", stalls, 0);

    // Randomised traffic with random sink and occasional re-keys.
    sink_mode = 2;
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 99);
      if (n < 3) begin
        install(rand_key(), 1'($urandom_range(0, 1)));
      end else if (n < 15) begin
        @(posedge clk);
        #1;
      end else begin
        mode = 1'($urandom_range(0, 1));
        if (!mode)
          d = ($urandom_range(0, 3) != 0) ? {8'($urandom), 8'(CHARSET[$urandom_range(0, 61)])}
                                          : 16'($urandom);
        else
          d = ($urandom_range(0, 3) != 0) ? {kb(mkey, rlist[$urandom_range(0, 5)]),
                                             kb(mkey, clist[$urandom_range(0, 5)])}
                                          : 16'($urandom);
        send(mode, d);
      end
    end
    sink_mode = 0;
    n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("drain_empty", q.size(), 0);

    // Reset during a key check with a result beat still held.
    install(K_GOOD, 1'b0);
    sink_mode = 1;
    @(posedge clk);
    #1;
    send(1'b0, 16'h0061);
    b1.key = K_GOOD;
    b1.key_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    b1.key_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    m_inst = 1'b0;
    #1;
    check_reset("midcheck");
    @(negedge clk);
    rst_n = 1'b1;
    sink_mode = 0;
    @(posedge clk);
    #1;

    // Block must be fully usable after that reset.
    install(K_GOOD, 1'b0);
    send(1'b0, 16'h0061);
    send(1'b0, 16'h0041);
    n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("final_drain_empty", q.size(), 0);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
